// File: rtl/seg7_decode_mon.sv
// Seven-segment display monitor: samples multiplexed segment/digit lines,
// debounces each pattern and decodes the committed patterns into nibbles.
module seg7_decode_mon #(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [6:0]        seg_n,
    input  logic [NDIG-1:0]   dig_sel,
    input  logic              err_clr,
    output logic [4*NDIG-1:0] value,
    output logic [NDIG-1:0]   digit_valid,
    output logic              err,
    output logic              upd
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [7:0] LAST = 8'(STABLE - 1);
    localparam logic [7:0] MAXC = 8'(STABLE);

    typedef enum logic {
        WAIT,
        HELD
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      cnt, cnt_nx;
    logic [6:0]      sreg, sprev;
    logic [NDIG-1:0] dreg, dprev;
    logic            primed;
    logic            changed;
    logic            commit;
    logic [4:0]      dec;
    logic            blank;
    logic            onehot;
    logic            multi;
    logic [IW-1:0]   idx;
    logic [3:0]      cur;

    function automatic logic [4:0] dec7(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h18:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // primed holds off the first compare so a freshly released block
    // always needs STABLE+1 edges before its first commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg   <= 7'h7F;
            dreg   <= '0;
            sprev  <= 7'h7F;
            dprev  <= '0;
            primed <= 1'b0;
        end else begin
            sreg   <= seg_n;
            dreg   <= dig_sel;
            sprev  <= sreg;
            dprev  <= dreg;
            primed <= 1'b1;
        end
    end

    assign changed = primed && ({sreg, dreg} != {sprev, dprev});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        if (!primed) begin
            cnt_nx = '0;
        end else if (changed) begin
            state_nx = WAIT;
            cnt_nx   = 8'd1;
        end else if (state == WAIT) begin
            if (cnt < MAXC) begin
                cnt_nx = cnt + 8'd1;
            end
            if (cnt == LAST) begin
                commit   = 1'b1;
                state_nx = HELD;
            end
        end
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (dreg[i]) begin
                idx = i[IW-1:0];
            end
        end
    end

    assign dec    = dec7(sreg);
    assign blank  = (sreg == 7'h7F);
    assign onehot = (dreg != '0) && ((dreg & (dreg - 1'b1)) == '0);
    assign multi  = (dreg != '0) && !onehot;
    assign cur    = value[{idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value       <= '0;
            digit_valid <= '0;
            err         <= 1'b0;
            upd         <= 1'b0;
        end else begin
            upd <= 1'b0;
            err <= (err & ~err_clr)
                 | (commit & ((onehot & ~dec[4] & ~blank) | multi));
            if (commit && onehot) begin
                if (dec[4]) begin
                    value[{idx, 2'b00} +: 4] <= dec[3:0];
                    digit_valid[idx]         <= 1'b1;
                    upd <= (cur != dec[3:0]) || !digit_valid[idx];
                end else if (blank) begin
                    digit_valid[idx] <= 1'b0;
                    upd              <= digit_valid[idx];
                end else begin
                    digit_valid[idx] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_decode_mon.sv
// Scoreboard bench for seg7_decode_mon: expected upd events are queued at
// stimulus time and matched by a monitor whenever upd is seen.
module tb_seg7_decode_mon;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        err_clr = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_sel = 4'h0;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        err;
    logic        upd;

    seg7_decode_mon #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .seg_n(seg_n),
        .dig_sel(dig_sel),
        .err_clr(err_clr),
        .value(value),
        .digit_valid(digit_valid),
        .err(err),
        .upd(upd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [15:0] v;
        logic [3:0]  dv;
        logic        e;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] d);
        seg_n   = s;
        dig_sel = d;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // commit lands STABLE+1 edges after the first edge that sees the pins
    task automatic exp_upd(input logic [15:0] v, input logic [3:0] dv, input logic e);
        ev_t x;
        x.at = cyc + STABLE + 1;
        x.v  = v;
        x.dv = dv;
        x.e  = e;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        ev_t x;
        if (reset_n && upd) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_upd: upd high at cycle %0d, none expected", cyc);
            end else begin
                x = q.pop_front();
                chk("upd_cycle", cyc, x.at);
                chk("upd_value", value, x.v);
                chk("upd_valid", digit_valid, x.dv);
                chk("upd_err", err, x.e);
            end
        end
    end

    logic [6:0]  segs[4] = '{7'h40, 7'h24, 7'h08, 7'h0E};
    logic [15:0] vals[4] = '{16'h0000, 16'h0020, 16'h0A20, 16'hFA20};
    logic [3:0]  dvs[4]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    initial begin
        #1;
        chk("rst_value", value, 16'h0);
        chk("rst_valid", digit_valid, 4'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_upd", upd, 1'b0);
        wait_n(3);
        reset_n = 1'b1;

        drive(7'h30, 4'b0001);
        exp_upd(16'h0003, 4'b0001, 1'b0);
        wait_n(10);
        chk("single_value", value, 16'h0003);

        drive(7'h12, 4'b0001);
        wait_n(3);
        drive(7'h79, 4'b0001);
        exp_upd(16'h0001, 4'b0001, 1'b0);
        wait_n(8);
        chk("glitch_value", value, 16'h0001);

        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < 4; d++) begin
                drive(segs[d], 4'(1 << d));
                if (p == 0) exp_upd(vals[d], dvs[d], 1'b0);
                wait_n(6);
            end
        end
        chk("scan_value", value, 16'hFA20);
        chk("scan_valid", digit_valid, 4'b1111);

        drive(7'h7F, 4'b0100);
        exp_upd(16'hFA20, 4'b1011, 1'b0);
        wait_n(6);
        chk("blank_err", err, 1'b0);
        chk("blank_valid", digit_valid, 4'b1011);

        drive(7'h55, 4'b0010);
        wait_n(6);
        chk("illegal_err", err, 1'b1);
        chk("illegal_valid", digit_valid, 4'b1001);
        chk("illegal_value", value, 16'hFA20);
        err_clr = 1'b1;
        wait_n(1);
        err_clr = 1'b0;
        chk("errclr", err, 1'b0);

        drive(7'h40, 4'b0011);
        wait_n(4);
        err_clr = 1'b1;
        wait_n(1);
        err_clr = 1'b0;
        chk("multi_err_wins", err, 1'b1);
        chk("multi_value", value, 16'hFA20);
        chk("multi_valid", digit_valid, 4'b1001);
        wait_n(3);
        err_clr = 1'b1;
        wait_n(1);
        err_clr = 1'b0;
        chk("errclr2", err, 1'b0);

        drive(7'h79, 4'b0000);
        wait_n(6);
        chk("nosel_value", value, 16'hFA20);
        chk("nosel_valid", digit_valid, 4'b1001);
        chk("nosel_err", err, 1'b0);

        drive(7'h19, 4'b0001);
        wait_n(3);
        reset_n = 1'b0;
        #1;
        chk("midrst_value", value, 16'h0);
        chk("midrst_valid", digit_valid, 4'h0);
        chk("midrst_err", err, 1'b0);
        chk("midrst_upd", upd, 1'b0);
        wait_n(2);
        reset_n = 1'b1;
        exp_upd(16'h0004, 4'b0001, 1'b0);
        wait_n(8);
        chk("post_rst_value", value, 16'h0004);

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
